// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception/interrupt controller.
// Detects interrupt/syscall/invalid/overflow/eret on the MEM-stage instruction
// using a CP0 view forwarded from the pending WB write. It then issues a
// one-cycle exception code to CP0 and holds a pipeline flush with a redirect PC.
// Optional build macro: INT_SYNC_EN adds a two-flop synchronizer on hw_int_i.
module except_ctrl #(
  parameter logic [31:0] VEC_OFFSET   = 32'h0000_0180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_excepttype_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] cp0_ebase_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic [5:0]  hw_int_i,
  input  logic        timer_int_i,
  output logic [5:0]  int_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] inst_addr_o,
  output logic        in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_EBASE  = 5'd15;

  localparam logic [31:0] E_NONE    = 32'h0;
  localparam logic [31:0] E_INT     = 32'h1;
  localparam logic [31:0] E_SYSCALL = 32'h8;
  localparam logic [31:0] E_INVALID = 32'ha;
  localparam logic [31:0] E_OVF     = 32'hc;
  localparam logic [31:0] E_ERET    = 32'he;

  // Flush counter reload; the first flush cycle is the event edge itself.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [5:0]  hw_sync;

  logic [31:0] fwd_status, fwd_cause, fwd_epc, fwd_ebase;
  logic        int_pending;
  logic [31:0] exc_code;
  logic        take_exc;
  logic [31:0] vec_pc, redirect_pc;

  // ---------------------------------------------------------------------------
  // Interrupt line conditioning
  // ---------------------------------------------------------------------------
`ifdef INT_SYNC_EN
  logic [5:0] sync_q1, sync_q2;

  // Two-flop synchronizer: hw_int_i is asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= hw_int_i;
      sync_q2 <= sync_q1;
    end
  end

  assign hw_sync = sync_q2;
`else
  assign hw_sync = hw_int_i;
`endif

  // Timer interrupt shares line 5 with external line 5.
  assign int_o = {hw_sync[5] | timer_int_i, hw_sync[4:0]};

  // ---------------------------------------------------------------------------
  // CP0 forwarding: a write sitting in WB is not yet visible in cp0_*_i
  // ---------------------------------------------------------------------------
  // Select the newest value of each CP0 register; only CAUSE.IP[1:0] is software-writable.
  always_comb begin
    fwd_status = cp0_status_i;
    fwd_cause  = cp0_cause_i;
    fwd_epc    = cp0_epc_i;
    fwd_ebase  = cp0_ebase_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_STATUS: fwd_status = wb_cp0_data_i;
        CP0_CAUSE:  fwd_cause[9:8] = wb_cp0_data_i[9:8];
        CP0_EPC:    fwd_epc = wb_cp0_data_i;
        CP0_EBASE:  fwd_ebase = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  // Interrupt needs an unmasked pending line, IE set and EXL clear.
  assign int_pending = ((fwd_cause[15:8] & fwd_status[15:8]) != 8'h00) &&
                       !fwd_status[1] && fwd_status[0];

  // ---------------------------------------------------------------------------
  // Event detection and redirect target
  // ---------------------------------------------------------------------------
  // Fixed priority encode; exactly one code wins.
  always_comb begin
    exc_code = E_NONE;
    if (int_pending)              exc_code = E_INT;
    else if (mem_excepttype_i[8])  exc_code = E_SYSCALL;
    else if (mem_excepttype_i[9])  exc_code = E_INVALID;
    else if (mem_excepttype_i[11]) exc_code = E_OVF;
    else if (mem_excepttype_i[12]) exc_code = E_ERET;
  end

  // Only a valid instruction seen while idle can raise an event, so MEM/WB inputs
  // are don't-care for the whole flush window.
  assign take_exc    = (state == IDLE) && mem_valid_i && (exc_code != E_NONE);
  assign vec_pc      = {fwd_ebase[31:12], 12'h000} + VEC_OFFSET;
  assign redirect_pc = (exc_code == E_ERET) ? fwd_epc : vec_pc;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: enter FLUSH on an event, leave once the counter has run out.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_exc)    state_nxt = FLUSH;
      FLUSH:   if (cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output-side registers: capture the event, then time out the flush window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= 4'd0;
      excepttype_o   <= E_NONE;
      inst_addr_o    <= 32'h0;
      in_delayslot_o <= 1'b0;
      flush_o        <= 1'b0;
      new_pc_o       <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          excepttype_o <= E_NONE;
          if (take_exc) begin
            excepttype_o   <= exc_code;
            inst_addr_o    <= mem_inst_addr_i;
            in_delayslot_o <= mem_in_delayslot_i;
            flush_o        <= 1'b1;
            new_pc_o       <= redirect_pc;
            cnt            <= CNT_INIT;
          end
        end
        FLUSH: begin
          // Code is a single-cycle pulse; flush stays up until the count expires.
          excepttype_o <= E_NONE;
          if (cnt == 4'd0) flush_o <= 1'b0;
          else             cnt     <= cnt - 4'd1;
        end
        default: begin
          excepttype_o <= E_NONE;
          flush_o      <= 1'b0;
        end
      endcase
    end
  end

  // Busy whenever the FSM is away from IDLE.
  always_comb begin
    busy_o = (state != IDLE);
  end

  // Register fields the controller does not interpret.
  logic unused_bits;
  assign unused_bits = ^{mem_excepttype_i[31:13], mem_excepttype_i[10],
                         mem_excepttype_i[7:0], fwd_status[31:16],
                         fwd_status[7:2], fwd_cause[31:16], fwd_cause[7:0],
                         fwd_ebase[11:0]};

endmodule
